// File: rtl/sar_adc_ctrl.sv
// rtl/sar_adc_ctrl.sv - successive-approximation ADC sequencer with masked channel scan
//
// Scans the channels set in chan_mask from lowest to highest. Each channel is
// tracked for SAMPLE_CYCLES clocks, then resolved MSB-first with one trial per bit.
// Results leave through a valid/ready output port.
//
// Ports:
//   wb_clk_i, wb_rst_ni          clock, asynchronous active-low reset
//   start, continuous, chan_mask scan request, auto-restart enable, channel set
//   cmp_in                       raw comparator (selected input >= DAC)
//   ch_sel, sample, dac_code     analog mux select, track enable, DAC trial code
//   busy                         scan in progress
//   out_valid, out_ready,
//   out_data, out_ch             conversion result handshake, code and channel
module sar_adc_ctrl #(
    parameter int WIDTH         = 8,
    parameter int CHANNELS      = 4,
    parameter int SAMPLE_CYCLES = 4,
    parameter int SETTLE_CYCLES = 2,
    localparam int CW           = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                wb_clk_i,
    input  logic                wb_rst_ni,
    input  logic                start,
    input  logic                continuous,
    input  logic [CHANNELS-1:0] chan_mask,
    input  logic                cmp_in,
    output logic [CW-1:0]       ch_sel,
    output logic                sample,
    output logic [WIDTH-1:0]    dac_code,
    output logic                busy,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [WIDTH-1:0]    out_data,
    output logic [CW-1:0]       out_ch
);
    // A trial covers DAC settling, two synchronizer stages and the decision clock.
    localparam int TRIAL_CYCLES = SETTLE_CYCLES + 3;
    localparam int BW           = $clog2(WIDTH);
    localparam int CNTW         = 16;

    typedef enum logic [1:0] {ST_IDLE, ST_SAMPLE, ST_TRIAL, ST_OUTPUT} state_t;

    state_t              state_q, state_d;
    logic [CNTW-1:0]     cnt_q;
    logic [BW-1:0]       bit_q;
    logic [WIDTH-1:0]    code_q;
    logic [WIDTH-1:0]    code_kept;
    logic [CHANNELS-1:0] mask_q;
    logic [CW-1:0]       ch_q;
    logic [CW-1:0]       data_ch_q;
    logic [WIDTH-1:0]    data_q;
    logic                sync1_q, sync2_q;
    logic                cnt_done, start_ok, last_bit;
    logic [CW-1:0]       first_new, first_latched, next_ch;
    logic                has_next;

    assign start_ok = start && (|chan_mask);
    assign last_bit = (bit_q == '0);
    // Current trial bit survives only if the synchronized comparator says input >= DAC.
    assign code_kept = sync2_q ? code_q : (code_q & ~(WIDTH'(1) << bit_q));

    always_comb begin
        cnt_done = 1'b0;
        case (state_q)
            ST_SAMPLE: cnt_done = (cnt_q == CNTW'(SAMPLE_CYCLES - 1));
            ST_TRIAL:  cnt_done = (cnt_q == CNTW'(TRIAL_CYCLES - 1));
            default:   cnt_done = 1'b0;
        endcase
    end

    // Lowest channel of the incoming mask, lowest of the latched mask, and the
    // next latched channel above the current one.
    always_comb begin
        first_new     = '0;
        first_latched = '0;
        next_ch       = '0;
        has_next      = 1'b0;
        for (int i = CHANNELS - 1; i >= 0; i--) begin
            if (chan_mask[i]) first_new = CW'(i);
            if (mask_q[i]) first_latched = CW'(i);
            if (mask_q[i] && (i > int'(ch_q))) begin
                next_ch  = CW'(i);
                has_next = 1'b1;
            end
        end
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= cmp_in;
            sync2_q <= sync1_q;
        end
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) state_q <= ST_IDLE;
        else            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (start_ok) state_d = ST_SAMPLE;
            ST_SAMPLE: if (cnt_done) state_d = ST_TRIAL;
            ST_TRIAL:  if (cnt_done && last_bit) state_d = ST_OUTPUT;
            ST_OUTPUT: begin
                if (out_ready) begin
                    if (has_next || continuous) state_d = ST_SAMPLE;
                    else                        state_d = ST_IDLE;
                end
            end
            default:   state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            cnt_q     <= '0;
            bit_q     <= '0;
            code_q    <= '0;
            mask_q    <= '0;
            ch_q      <= '0;
            data_ch_q <= '0;
            data_q    <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start_ok) begin
                        mask_q <= chan_mask;
                        ch_q   <= first_new;
                        cnt_q  <= '0;
                    end
                end
                ST_SAMPLE: begin
                    if (cnt_done) begin
                        cnt_q  <= '0;
                        bit_q  <= BW'(WIDTH - 1);
                        code_q <= WIDTH'(1) << (WIDTH - 1);
                    end else begin
                        cnt_q <= cnt_q + CNTW'(1);
                    end
                end
                ST_TRIAL: begin
                    if (cnt_done) begin
                        cnt_q <= '0;
                        if (last_bit) begin
                            data_q    <= code_kept;
                            data_ch_q <= ch_q;
                            code_q    <= '0;
                        end else begin
                            bit_q  <= bit_q - BW'(1);
                            code_q <= code_kept | (WIDTH'(1) << (bit_q - BW'(1)));
                        end
                    end else begin
                        cnt_q <= cnt_q + CNTW'(1);
                    end
                end
                ST_OUTPUT: begin
                    // Restart at the lowest latched channel when the scan wraps;
                    // if the scan ends instead, ch_q just parks on a legal channel.
                    if (out_ready) begin
                        cnt_q <= '0;
                        ch_q  <= has_next ? next_ch : first_latched;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        sample    = (state_q == ST_SAMPLE);
        dac_code  = (state_q == ST_TRIAL) ? code_q : '0;
        busy      = (state_q != ST_IDLE);
        out_valid = (state_q == ST_OUTPUT);
        out_data  = data_q;
        out_ch    = data_ch_q;
        ch_sel    = ch_q;
    end

endmodule

// File: tb/tb_sar_adc_ctrl.sv
// tb/tb_sar_adc_ctrl.sv - self-checking bench for sar_adc_ctrl
`timescale 1ns/1ps
module tb_sar_adc_ctrl;
    localparam int CW = 2;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          continuous = 1'b0;
    logic          out_ready = 1'b1;
    logic [3:0]    chan_mask = 4'b0000;
    logic          cmp_in;
    logic [CW-1:0] ch_sel, out_ch;
    logic          sample, busy, out_valid;
    logic [7:0]    dac_code, out_data;
    logic [7:0]    vin [4];

    int         vectors = 0;
    int         errors = 0;
    int         xfer_cnt = 0;
    int         exp_ch [$];
    logic [7:0] exp_data [$];
    logic [7:0] exp_trials [$];
    logic [7:0] obs_trials [$];
    logic [3:0] exp_mask = 4'b0000;

    sar_adc_ctrl #(
        .WIDTH(8), .CHANNELS(4), .SAMPLE_CYCLES(4), .SETTLE_CYCLES(2)
    ) dut (
        .wb_clk_i(clk), .wb_rst_ni(rst_n), .start(start), .continuous(continuous),
        .chan_mask(chan_mask), .cmp_in(cmp_in), .ch_sel(ch_sel), .sample(sample),
        .dac_code(dac_code), .busy(busy), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_ch(out_ch)
    );

    always #5 clk = ~clk;

    // Ideal comparator: selected analog input against the DAC.
    assign cmp_in = (vin[ch_sel] >= dac_code);

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Binary search of an ideal comparator: queue every trial code and the result.
    task automatic push_conv(input int ch, input logic [7:0] v, input logic [7:0] lit);
        logic [7:0] code, t;
        code = 8'h00;
        for (int b = 7; b >= 0; b--) begin
            t = code | (8'h01 << b);
            exp_trials.push_back(t);
            if (v >= t) code = t;
        end
        check("model_vs_hand", code, lit);
        exp_ch.push_back(ch);
        exp_data.push_back(lit);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_xfer(input int target, input int budget);
        int n;
        n = 0;
        while (xfer_cnt < target && n < budget) begin
            tick();
            n++;
        end
        check("xfer_within_budget", xfer_cnt >= target, 1);
    endtask

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        while (busy && n < budget) begin
            tick();
            n++;
        end
        check("idle_within_budget", busy, 0);
    endtask

    initial begin : compare
        logic       prev_valid, prev_ready;
        logic [7:0] prev_data, prev_dac;
        logic [1:0] prev_ch;
        prev_valid = 1'b0; prev_ready = 1'b0; prev_data = 8'h00; prev_dac = 8'h00; prev_ch = 2'd0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_valid = 1'b0;
                prev_dac   = 8'h00;
            end else begin
                if (busy) check("ch_in_mask", exp_mask[ch_sel], 1);
                else      check("idle_quiet", {sample, out_valid, dac_code}, 0);
                if (sample || out_valid) check("dac_zero_outside_trial", dac_code, 0);
                if (prev_valid && !prev_ready) begin
                    check("stall_valid", out_valid, 1);
                    check("stall_data", out_data, prev_data);
                    check("stall_ch", out_ch, prev_ch);
                end
                if (dac_code != 8'h00 && dac_code != prev_dac) begin
                    obs_trials.push_back(dac_code);
                    check("trial_expected", exp_trials.size() > 0, 1);
                    if (exp_trials.size() > 0) check("trial_code", dac_code, exp_trials.pop_front());
                end
                if (out_valid && out_ready) begin
                    xfer_cnt++;
                    check("result_expected", exp_data.size() > 0, 1);
                    if (exp_data.size() > 0) begin
                        check("result_ch", out_ch, exp_ch.pop_front());
                        check("result_data", out_data, exp_data.pop_front());
                    end
                end
                prev_valid = out_valid;
                prev_ready = out_ready;
                prev_data  = out_data;
                prev_ch    = out_ch;
                prev_dac   = dac_code;
            end
        end
    end

    initial begin : watchdog
        #300000;
        $display("FAIL watchdog: simulation exceeded its time limit");
        $fatal(1, "watchdog");
    end

    initial begin : driver
        int         n, base, samp, vcnt;
        logic [7:0] lit_a5 [8];
        lit_a5 = '{8'h80, 8'hC0, 8'hA0, 8'hB0, 8'hA8, 8'hA4, 8'hA6, 8'hA5};
        vin = '{default: 8'h00};

        // Reset values
        repeat (3) tick();
        check("rst_busy", busy, 0);
        check("rst_sample", sample, 0);
        check("rst_valid", out_valid, 0);
        check("rst_dac", dac_code, 0);
        check("rst_data", out_data, 0);
        check("rst_out_ch", out_ch, 0);
        check("rst_ch_sel", ch_sel, 0);

        // Start held across reset release is accepted on the first edge
        vin[0] = 8'h3C; chan_mask = 4'b0001; exp_mask = 4'b0001;
        push_conv(0, 8'h3C, 8'h3C);
        start = 1'b1;
        rst_n = 1'b1;
        tick();
        start = 1'b0;
        check("first_edge_accept", busy, 1);
        wait_xfer(1, 100);
        wait_idle(10);

        // Start with an empty mask is ignored
        chan_mask = 4'b0000;
        pulse_start();
        check("empty_mask_ignored", busy, 0);
        tick();
        check("empty_mask_still_idle", busy, 0);

        // 0xA5 on channel 0: latency, data and trial sequence
        vin[0] = 8'hA5; chan_mask = 4'b0001; exp_mask = 4'b0001;
        push_conv(0, 8'hA5, 8'hA5);
        base = obs_trials.size();
        pulse_start();
        n = 1;
        while (!out_valid && n < 100) begin
            tick();
            n++;
        end
        check("latency", n, 45);
        check("a5_data", out_data, 8'hA5);
        check("a5_ch", out_ch, 0);
        tick();
        check("a5_busy_after", busy, 0);
        check("a5_trial_count", obs_trials.size() - base, 8);
        for (int k = 0; k < 8; k++)
            if (base + k < obs_trials.size()) check("a5_trial", obs_trials[base + k], lit_a5[k]);

        // Full scale and zero
        vin[0] = 8'hFF;
        push_conv(0, 8'hFF, 8'hFF);
        pulse_start();
        wait_xfer(3, 100);
        wait_idle(10);
        vin[0] = 8'h00;
        push_conv(0, 8'h00, 8'h00);
        base = obs_trials.size();
        pulse_start();
        wait_xfer(4, 100);
        wait_idle(10);
        check("zero_trial_count", obs_trials.size() - base, 8);
        for (int k = 0; k < 8; k++)
            if (base + k < obs_trials.size()) check("zero_trial", obs_trials[base + k], 8'h80 >> k);

        // Sparse mask: channels 1 then 3 only
        vin[1] = 8'h12; vin[3] = 8'hEE; chan_mask = 4'b1010; exp_mask = 4'b1010;
        push_conv(1, 8'h12, 8'h12);
        push_conv(3, 8'hEE, 8'hEE);
        pulse_start();
        wait_xfer(6, 200);
        wait_idle(10);

        // Consumer stall on the first result
        vin[0] = 8'h81; vin[1] = 8'h7E; chan_mask = 4'b0011; exp_mask = 4'b0011;
        push_conv(0, 8'h81, 8'h81);
        push_conv(1, 8'h7E, 8'h7E);
        out_ready = 1'b0;
        pulse_start();
        n = 0;
        while (!out_valid && n < 100) begin
            tick();
            n++;
        end
        check("stall_first_valid", out_valid, 1);
        samp = 0;
        repeat (20) begin
            tick();
            if (sample) samp++;
        end
        check("stall_no_sample", samp, 0);
        check("stall_hold_data", out_data, 8'h81);
        check("stall_hold_ch", out_ch, 0);
        out_ready = 1'b1;
        wait_xfer(8, 200);
        wait_idle(10);

        // Continuous scan, ignored starts, mid-scan mask change
        vin[2] = 8'h5B; chan_mask = 4'b0100; exp_mask = 4'b0100;
        continuous = 1'b1;
        repeat (4) push_conv(2, 8'h5B, 8'h5B);
        base = xfer_cnt;
        pulse_start();
        tick();
        chan_mask = 4'b1011;
        wait_xfer(base + 1, 100);
        pulse_start();
        wait_xfer(base + 3, 200);
        continuous = 1'b0;
        pulse_start();
        wait_xfer(base + 4, 100);
        wait_idle(10);
        repeat (60) tick();
        check("cont_total_results", xfer_cnt - base, 4);

        // Reset in the bit-4 trial of a conversion
        vin[0] = 8'h5A; chan_mask = 4'b0001; exp_mask = 4'b0001;
        push_conv(0, 8'h5A, 8'h5A);
        pulse_start();
        repeat (21) tick();
        check("pre_reset_trial", dac_code, 8'h50);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_busy", busy, 0);
        check("mid_rst_sample", sample, 0);
        check("mid_rst_valid", out_valid, 0);
        check("mid_rst_dac", dac_code, 0);
        check("mid_rst_data", out_data, 0);
        check("mid_rst_out_ch", out_ch, 0);
        check("mid_rst_ch_sel", ch_sel, 0);
        exp_ch.delete();
        exp_data.delete();
        exp_trials.delete();
        tick();
        tick();
        rst_n = 1'b1;
        base = xfer_cnt;
        vcnt = 0;
        repeat (60) begin
            tick();
            if (out_valid || busy) vcnt++;
        end
        check("post_reset_quiet", vcnt, 0);
        check("post_reset_no_result", xfer_cnt - base, 0);

        check("leftover_results", exp_data.size(), 0);
        check("leftover_trials", exp_trials.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule

// File: doc/sar_adc_ctrl.md
SAR_ADC_CTRL -- requirements
Module: sar_adc_ctrl

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, meaning conversion resolution in bits (legal range 2..16).
REQ-002 The block SHALL have parameter CHANNELS, default 4, meaning the number of muxed analog inputs (legal range 1..16).
REQ-003 The block SHALL have parameter SAMPLE_CYCLES, default 4, meaning track-phase length in clocks (legal minimum 1).
REQ-004 The block SHALL have parameter SETTLE_CYCLES, default 2, meaning DAC settling clocks per bit trial (legal minimum 0).
REQ-005 The block SHALL define CW = max(1, clog2(CHANNELS)) as its derived channel-index width.
REQ-006 The block SHALL have port wb_clk_i, input, width 1: the single clock; all logic is rising-edge.
REQ-007 The block SHALL have port wb_rst_ni, input, width 1: reset, asynchronous assert, active-low.
REQ-008 The block SHALL have port start, input, width 1: single-cycle request to begin a scan.
REQ-009 The block SHALL have port continuous, input, width 1: restart the scan after the last channel while high.
REQ-010 The block SHALL have port chan_mask, input, width CHANNELS: the channels included in a scan.
REQ-011 The block SHALL have port cmp_in, input, width 1: asynchronous comparator output (vp = selected input, vn = DAC).
REQ-012 The block SHALL have port ch_sel, output, width CW: the analog mux select.
REQ-013 The block SHALL have port sample, output, width 1: the sample-and-hold track enable.
REQ-014 The block SHALL have port dac_code, output, width WIDTH: the trial code to the DAC.
REQ-015 The block SHALL have port busy, output, width 1: high from start acceptance until the scan ends.
REQ-016 The block SHALL have port out_valid, output, width 1: result available.
REQ-017 The block SHALL have port out_ready, input, width 1: consumer accepts the result.
REQ-018 The block SHALL have port out_data, output, width WIDTH: the conversion result.
REQ-019 The block SHALL have port out_ch, output, width CW: the channel of out_data.

Function
REQ-020 The block SHALL pass cmp_in through a 2-flop synchronizer, and all decisions SHALL use only the synchronized value.
REQ-021 The block SHALL implement FSM states IDLE, SAMPLE, TRIAL, OUTPUT.
REQ-022 In IDLE, start=1 with chan_mask≠0 SHALL latch chan_mask, select the lowest set channel and enter SAMPLE; start with mask=0 SHALL be ignored.
REQ-023 start SHALL be ignored in any state other than IDLE.
REQ-024 SAMPLE SHALL hold sample=1 for exactly SAMPLE_CYCLES clocks, then enter TRIAL with bit index WIDTH-1.
REQ-025 On entering each bit trial, the block SHALL set dac_code = (accepted bits) | (1<<i) with lower bits 0.
REQ-026 Each bit trial SHALL last exactly SETTLE_CYCLES+3 clocks.
REQ-027 On the last clock of a trial, bit i SHALL be kept if the synchronized cmp=1 and cleared otherwise.
REQ-028 After bit 0 is decided, the final code SHALL be registered to out_data/out_ch with out_valid=1 and the FSM SHALL enter OUTPUT.
REQ-029 Latency from the start edge to out_valid rising SHALL be 1 + SAMPLE_CYCLES + WIDTH*(SETTLE_CYCLES+3) clocks.
REQ-030 In OUTPUT, the result SHALL be transferred on out_valid & out_ready.
REQ-031 While out_ready=0, out_valid, out_data and out_ch SHALL hold stable and the FSM SHALL stall.
REQ-032 After the transfer, the FSM SHALL go to SAMPLE for the next higher set bit of the latched mask.
REQ-033 If the transferred channel was the highest set bit, the FSM SHALL restart at the lowest set channel if continuous=1, else go to IDLE with busy=0 on the following clock.
REQ-034 continuous SHALL be sampled only at the end-of-scan decision.
REQ-035 A chan_mask change mid-scan SHALL have no effect until the next start/restart.
REQ-036 Bits of chan_mask at or above CHANNELS do not exist, and ch_sel SHALL never exceed CHANNELS-1.
REQ-037 dac_code SHALL be 0 whenever the FSM is not in TRIAL.
REQ-038 sample SHALL be 0 whenever the FSM is not in SAMPLE.

Reset
REQ-039 wb_rst_ni=0 SHALL asynchronously force IDLE with sample=0, busy=0, out_valid=0, dac_code=0, out_data=0, out_ch=0, ch_sel=0, synchronizer=0 and latched mask=0.
REQ-040 Reset asserted mid-conversion or mid-stall SHALL discard the partial result, and no out_valid SHALL follow release.
REQ-041 After reset release, the block SHALL accept start on the first rising edge.

Verification
REQ-042 Scenario WIDTH=8, SAMPLE_CYCLES=4, SETTLE_CYCLES=2, comparator model (input code >= dac_code), input 0xA5, mask 4'b0001, out_ready=1 -> out_data=0xA5, out_ch=0, out_valid 45 clocks after start, busy low afterwards.
REQ-043 Scenario with inputs 0xFF and 0x00 -> out_data=0xFF and 0x00 respectively; the dac_code trial sequence for 0x00 is 0x80,0x40,...,0x01.
REQ-044 Scenario mask 4'b1010 with inputs ch1=0x12, ch3=0xEE -> results ch1/0x12 then ch3/0xEE in that order; ch_sel is never 0 or 2.
REQ-045 Scenario out_ready held low for 20 clocks on the first result -> out_valid and out_data are stable throughout, no second sample pulse occurs, and the transfer completes when ready rises.
REQ-046 Scenario continuous=1, mask 4'b0100, 3 results, then continuous=0 -> exactly one further result follows, then busy=0; start pulses sent while busy produce no extra conversions.
REQ-047 Scenario reset at bit 4 of a trial -> all outputs reach reset values immediately and no out_valid appears for 60 clocks after release without start.
